// File: rtl/flappy_pkg.sv
// Shared definitions for the flappy game pipeline: movement-stage direction codes,
// the input-stage state enum and the length of the reset hold.
package flappy_pkg;

  localparam logic [2:0] DIR_START = 3'b000;
  localparam logic [2:0] DIR_UP    = 3'b010;
  localparam logic [2:0] DIR_DOWN  = 3'b100;
  localparam logic [2:0] DIR_RESET = 3'b111;

  localparam int RST_TICKS = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RISE,
    ST_FALL,
    ST_OVER,
    ST_RST
  } state_e;

  function automatic logic [2:0] dir_of(state_e s);
    logic [2:0] d;
    case (s)
      ST_RISE: d = DIR_UP;
      ST_FALL: d = DIR_DOWN;
      ST_RST:  d = DIR_RESET;
      default: d = DIR_START;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button: 2-FF synchroniser, counting debouncer and a single-cycle press pulse
// on each debounced rising edge.
module btn_debounce
  import flappy_pkg::*;
#(
  parameter int DEB_CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic level,
  output logic press
);

  localparam int CW = $clog2(DEB_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEB_CYCLES - 1);

  logic          sync1_q, sync1_d;
  logic          sync2_q, sync2_d;
  logic          level_q, level_d;
  logic          press_q, press_d;
  logic          armed_q, armed_d;
  logic [1:0]    vld_q, vld_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // A button already held when reset drops must not fire: presses stay disarmed
  // until the synchronised input has been seen low at least once.
  always_comb begin
    sync1_d = btn_raw;
    sync2_d = sync1_q;
    vld_d   = {vld_q[0], 1'b1};
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = ~level_q;
      end else begin
        cnt_d = cnt_q + CW'(1);
      end
    end
    press_d = level_d & ~level_q & armed_q;
    armed_d = armed_q | (vld_q[1] & ~sync2_q);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      armed_q <= 1'b0;
      vld_q   <= '0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= sync1_d;
      sync2_q <= sync2_d;
      level_q <= level_d;
      press_q <= press_d;
      armed_q <= armed_d;
      vld_q   <= vld_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/flap_input.sv
// Flap/reset button front end: debounces both buttons, generates the game tick and
// drives the movement-stage dir command. Optional macro FLAP_HOLD_EN extends a flap while held.
module flap_input
  import flappy_pkg::*;
#(
  parameter int DEB_CYCLES = 500000,
  parameter int TICK_DIV   = 2500000,
  parameter int FLAP_TICKS = 3,
  parameter int OVER_HOLD  = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       btn_flap,
  input  logic       btn_rst,
  input  logic       game_over,
  output logic [2:0] dir,
  output logic       tick
);

  localparam int TW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam int FW = (FLAP_TICKS > 1) ? $clog2(FLAP_TICKS) : 1;
  localparam int OW = (OVER_HOLD > 0) ? $clog2(OVER_HOLD + 1) : 1;
  localparam int HW = $clog2(RST_TICKS);

  localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [FW-1:0] FLAP_LAST = FW'(FLAP_TICKS - 1);
  localparam logic [OW-1:0] OVER_LAST = OW'(OVER_HOLD);
  localparam logic [HW-1:0] HOLD_LAST = HW'(RST_TICKS - 1);

  logic flap_level, flap_press;
  logic rst_level, rst_press;
  logic unused_levels;

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_flap_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_flap),
    .level   (flap_level),
    .press   (flap_press)
  );

  btn_debounce #(.DEB_CYCLES(DEB_CYCLES)) u_rst_btn (
    .clk     (clk),
    .reset   (reset),
    .btn_raw (btn_rst),
    .level   (rst_level),
    .press   (rst_press)
  );

  assign unused_levels = rst_level ^ flap_level;

  state_e        state_q, state_d;
  logic [2:0]    dir_q, dir_d;
  logic [TW-1:0] tick_cnt_q, tick_cnt_d;
  logic [FW-1:0] flap_cnt_q, flap_cnt_d;
  logic [OW-1:0] over_cnt_q, over_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic          go_s1_q, go_s1_d;
  logic          go_s2_q, go_s2_d;
  logic          go_prev_q, go_prev_d;
  logic          go_edge;
  logic          hold_block;

  always_comb begin
    tick_cnt_d = (tick_cnt_q == TICK_LAST) ? '0 : tick_cnt_q + TW'(1);
    go_s1_d    = game_over;
    go_s2_d    = go_s1_q;
    go_prev_d  = go_s2_q;
  end

  assign tick    = (tick_cnt_q == TICK_LAST);
  assign go_edge = go_s2_q & ~go_prev_q;

`ifdef FLAP_HOLD_EN
  assign hold_block = flap_level;
`else
  assign hold_block = 1'b0;
`endif

  // Same-cycle priority is encoded by the if/else order: rst press, game_over edge,
  // flap press, then tick expiry.
  always_comb begin
    state_d    = state_q;
    flap_cnt_d = flap_cnt_q;
    over_cnt_d = over_cnt_q;
    hold_cnt_d = hold_cnt_q;
    if (rst_press) begin
      state_d    = ST_RST;
      hold_cnt_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (flap_press) begin
            state_d    = ST_RISE;
            flap_cnt_d = '0;
          end
        end
        ST_RISE: begin
          if (go_edge) begin
            state_d    = ST_OVER;
            over_cnt_d = '0;
          end else if (flap_press) begin
            flap_cnt_d = '0;
          end else if (tick) begin
            if (flap_cnt_q != FLAP_LAST) begin
              flap_cnt_d = flap_cnt_q + FW'(1);
            end else if (!hold_block) begin
              state_d    = ST_FALL;
              flap_cnt_d = '0;
            end
          end
        end
        ST_FALL: begin
          if (go_edge) begin
            state_d    = ST_OVER;
            over_cnt_d = '0;
          end else if (flap_press) begin
            state_d    = ST_RISE;
            flap_cnt_d = '0;
          end
        end
        ST_OVER: begin
          if (flap_press && over_cnt_q == OVER_LAST) begin
            state_d    = ST_RISE;
            flap_cnt_d = '0;
          end else if (tick && over_cnt_q != OVER_LAST) begin
            over_cnt_d = over_cnt_q + OW'(1);
          end
        end
        ST_RST: begin
          if (tick) begin
            if (hold_cnt_q == HOLD_LAST) begin
              state_d    = ST_IDLE;
              hold_cnt_d = '0;
            end else begin
              hold_cnt_d = hold_cnt_q + HW'(1);
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
    dir_d = dir_of(state_d);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      dir_q      <= DIR_START;
      tick_cnt_q <= '0;
      flap_cnt_q <= '0;
      over_cnt_q <= '0;
      hold_cnt_q <= '0;
      go_s1_q    <= 1'b0;
      go_s2_q    <= 1'b0;
      go_prev_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      dir_q      <= dir_d;
      tick_cnt_q <= tick_cnt_d;
      flap_cnt_q <= flap_cnt_d;
      over_cnt_q <= over_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      go_s1_q    <= go_s1_d;
      go_s2_q    <= go_s2_d;
      go_prev_q  <= go_prev_d;
    end
  end

  assign dir = dir_q;

endmodule

// File: tb/tb_flap_input.sv
// Testbench for flap_input: a cycle-level reference model predicts every dir change
// and the tick pulse; a negedge monitor pops predictions and compares against the DUT.
module tb_flap_input;

  localparam int DEB_CYCLES = 4;
  localparam int TICK_DIV   = 10;
  localparam int FLAP_TICKS = 3;
  localparam int OVER_HOLD  = 2;

  localparam int M_IDLE = 0;
  localparam int M_RISE = 1;
  localparam int M_FALL = 2;
  localparam int M_OVER = 3;
  localparam int M_RST  = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic       btn_flap;
  logic       btn_rst;
  logic       game_over;
  logic [2:0] dir;
  logic       tick;

  int n_vec = 0;
  int n_err = 0;

  flap_input #(
    .DEB_CYCLES (DEB_CYCLES),
    .TICK_DIV   (TICK_DIV),
    .FLAP_TICKS (FLAP_TICKS),
    .OVER_HOLD  (OVER_HOLD)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .btn_flap  (btn_flap),
    .btn_rst   (btn_rst),
    .game_over (game_over),
    .dir       (dir),
    .tick      (tick)
  );

  always #5 clk = ~clk;

  // Compare one value and report a failure line if it differs.
  task automatic checkOutput(input string name, input int actual, input int expected);
    n_vec++;
    if (actual != expected) begin
      n_err++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Hold the given input levels for n clock cycles, changing them just after a rising edge.
  task automatic applyStimulus(input logic f, input logic r, input logic g, input int n);
    btn_flap  = f;
    btn_rst   = r;
    game_over = g;
    repeat (n) begin
      @(posedge clk);
      #2;
    end
  endtask

  // Reference model of one button: synchronised sample stream, a run of differing
  // samples flips the level, and a rising flip fires a press only once released since reset.
  typedef struct {
    bit p1;
    bit p2;
    bit lvl;
    bit armed;
    bit evt;
    int run;
  } btn_m_t;

  typedef struct {
    int         cyc;
    logic [2:0] dir;
  } exp_t;

  function automatic btn_m_t step_btn(btn_m_t b, bit raw, int k);
    btn_m_t n;
    bit s;
    n     = b;
    s     = b.p2;
    n.evt = 1'b0;
    if (s != b.lvl) begin
      n.run = b.run + 1;
      if (n.run == DEB_CYCLES) begin
        n.lvl = ~b.lvl;
        n.run = 0;
        n.evt = n.lvl & b.armed;
      end
    end else begin
      n.run = 0;
    end
    if (k >= 3 && !s) n.armed = 1'b1;
    n.p2 = b.p1;
    n.p1 = raw;
    return n;
  endfunction

  function automatic logic [2:0] dir_for(int st);
    case (st)
      M_RISE:  return 3'b010;
      M_FALL:  return 3'b100;
      M_RST:   return 3'b111;
      default: return 3'b000;
    endcase
  endfunction

  btn_m_t     m_f, m_r;
  bit         g_p1, g_p2, g_prev;
  int         abs_cyc = 0;
  int         cyc = 0;
  int         m_state = M_IDLE;
  int         m_left, m_over_ticks, m_rst_left;
  logic [2:0] m_dir_prev = 3'b000;
  exp_t       exp_q[$];

  // Reference model: advances once per rising edge and queues every dir change it predicts.
  always @(posedge clk) begin
    bit   fp, rp, ge, mt, held;
    exp_t e;
    abs_cyc++;
    if (reset) begin
      cyc     = 0;
      m_f     = '{default: 0};
      m_r     = '{default: 0};
      g_p1    = 0;
      g_p2    = 0;
      g_prev  = 0;
      m_state = M_IDLE;
    end else begin
      cyc++;
      mt   = ((cyc - 1) % TICK_DIV) == TICK_DIV - 1;
      ge   = g_p2 & ~g_prev;
      fp   = m_f.evt;
      rp   = m_r.evt;
`ifdef FLAP_HOLD_EN
      held = m_f.lvl;
`else
      held = 1'b0;
`endif
      if (rp) begin
        m_state    = M_RST;
        m_rst_left = 2;
      end else if ((m_state == M_RISE || m_state == M_FALL) && ge) begin
        m_state      = M_OVER;
        m_over_ticks = 0;
      end else if (fp && (m_state == M_IDLE || m_state == M_RISE || m_state == M_FALL ||
                          (m_state == M_OVER && m_over_ticks >= OVER_HOLD))) begin
        m_state = M_RISE;
        m_left  = FLAP_TICKS;
      end else if (mt) begin
        if (m_state == M_RISE) begin
          if (m_left > 1) m_left--;
          else if (!held) m_state = M_FALL;
        end else if (m_state == M_OVER) begin
          if (m_over_ticks < OVER_HOLD) m_over_ticks++;
        end else if (m_state == M_RST) begin
          m_rst_left--;
          if (m_rst_left == 0) m_state = M_IDLE;
        end
      end
      m_f    = step_btn(m_f, btn_flap, cyc);
      m_r    = step_btn(m_r, btn_rst, cyc);
      g_prev = g_p2;
      g_p2   = g_p1;
      g_p1   = game_over;
    end
    if (dir_for(m_state) != m_dir_prev) begin
      e.cyc = abs_cyc;
      e.dir = dir_for(m_state);
      exp_q.push_back(e);
      m_dir_prev = e.dir;
    end
  end

  bit         mon_en = 1'b0;
  logic [2:0] mon_last = 3'b000;

  // Monitor: every DUT dir change consumes one prediction; a prediction left too long is a miss.
  always @(negedge clk) begin
    exp_t e;
    if (mon_en) begin
      if (dir !== mon_last) begin
        if (exp_q.size() == 0) begin
          checkOutput("dir_unexpected_change", int'(dir), int'(mon_last));
        end else begin
          e = exp_q.pop_front();
          checkOutput("dir_value", int'(dir), int'(e.dir));
          checkOutput("dir_change_cycle", abs_cyc, e.cyc);
        end
        mon_last = dir;
      end else if (exp_q.size() > 0 && abs_cyc > exp_q[0].cyc + 3) begin
        e = exp_q.pop_front();
        checkOutput("dir_missing_change", int'(dir), int'(e.dir));
      end
      checkOutput("tick", int'(tick), int'((cyc % TICK_DIV) == TICK_DIV - 1));
    end
  end

  initial begin
    $display("[TB] start");
    reset     = 1'b1;
    btn_flap  = 1'b0;
    btn_rst   = 1'b0;
    game_over = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #2;
    end
    checkOutput("reset_dir", int'(dir), 0);
    checkOutput("reset_tick", int'(tick), 0);
    mon_last = 3'b000;
    mon_en   = 1'b1;
    reset    = 1'b0;

    // Basic flap: rise, then fall three ticks later.
    applyStimulus(0, 0, 0, 5);
    applyStimulus(1, 0, 0, 8);
    applyStimulus(0, 0, 0, 60);
    checkOutput("flap_then_down", int'(dir), 3'b100);

    // Collision in FALL, early press ignored, later press accepted.
    applyStimulus(0, 0, 1, 6);
    checkOutput("over_dir", int'(dir), 3'b000);
    applyStimulus(1, 0, 1, 8);
    applyStimulus(0, 0, 1, 30);
    applyStimulus(1, 0, 1, 8);
    applyStimulus(0, 0, 1, 6);
    checkOutput("over_late_press_up", int'(dir), 3'b010);
    applyStimulus(0, 0, 0, 40);

    // Reset and flap pressed together: reset wins, holds two ticks.
    applyStimulus(1, 1, 0, 8);
    applyStimulus(0, 0, 0, 6);
    checkOutput("rst_priority", int'(dir), 3'b111);
    applyStimulus(0, 0, 0, 30);
    checkOutput("rst_back_idle", int'(dir), 3'b000);

    // Bouncing button never reaches a stable level.
    for (int i = 0; i < 10; i++) begin
      applyStimulus(1, 0, 0, 2);
      applyStimulus(0, 0, 0, 2);
    end
    applyStimulus(0, 0, 0, 10);
    checkOutput("bounce_no_press", int'(dir), 3'b000);

    // Long hold.
    applyStimulus(1, 0, 0, 60);
`ifdef FLAP_HOLD_EN
    checkOutput("long_hold", int'(dir), 3'b010);
`else
    checkOutput("long_hold", int'(dir), 3'b100);
`endif
    applyStimulus(0, 0, 0, 30);

    // Reset mid-RISE with the button still held.
    applyStimulus(1, 0, 0, 12);
    reset = 1'b1;
    applyStimulus(1, 0, 0, 3);
    reset = 1'b0;
    applyStimulus(1, 0, 0, 20);
    checkOutput("held_through_reset", int'(dir), 3'b000);
    applyStimulus(0, 0, 0, 10);
    applyStimulus(1, 0, 0, 8);
    applyStimulus(0, 0, 0, 20);

    // Randomised play.
    for (int i = 0; i < 300; i++) begin
      applyStimulus(1'($urandom_range(0, 1)),
                    1'($urandom_range(0, 15) == 0),
                    1'($urandom_range(0, 3) == 0),
                    int'($urandom_range(1, 12)));
    end
    applyStimulus(0, 0, 0, 60);

    checkOutput("scoreboard_drained", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/flap_input.md
FLAP_INPUT -- requirements
Module: flap_input

Interface
REQ-001 SHALL provide parameter DEB_CYCLES, default 500000: cycles a synchronised button must be stable before its debounced level changes.
REQ-002 SHALL provide parameter TICK_DIV, default 2500000: clk cycles per game tick, matching the movement stage's update period.
REQ-003 SHALL provide parameter FLAP_TICKS, default 3: game ticks one flap holds dir at UP.
REQ-004 SHALL provide parameter OVER_HOLD, default 2: minimum ticks spent in OVER before a flap is accepted.
REQ-005 clk  input  1  system clock; single clock domain.
REQ-006 reset  input  1  synchronous, active-high reset.
REQ-007 btn_flap  input  1  raw asynchronous flap button, active-high.
REQ-008 btn_rst  input  1  raw asynchronous game-reset button, active-high.
REQ-009 game_over  input  1  reset2 from the movement stage; high on collision and while that stage is in START.
REQ-010 dir  output  3  command to the movement stage: 000 START/idle, 010 UP, 100 DOWN, 111 RESET.
REQ-011 tick  output  1  one-cycle pulse every TICK_DIV cycles.

Function
REQ-012 Each button SHALL pass a 2-FF synchroniser, then a debouncer that flips its level only after DEB_CYCLES consecutive cycles of differing samples; any agreeing sample clears the count.
REQ-013 A press event SHALL be a one-cycle pulse on a debounced 0->1 transition; holding a button SHALL NOT produce further events.
REQ-014 tick SHALL come from a free-running counter 0..TICK_DIV-1 and pulse in the cycle the count equals TICK_DIV-1, then wrap to 0.
REQ-015 States SHALL be IDLE (dir=000), RISE (010), FALL (100), OVER (000), RST (111); dir is a registered Moore output of the state.
REQ-016 IDLE: flap press -> RISE with flap_cnt=0.
REQ-017 RISE: each tick increments flap_cnt; a tick while flap_cnt==FLAP_TICKS-1 -> FALL; a flap press restarts flap_cnt at 0 and stays in RISE.
REQ-018 FALL: flap press -> RISE with flap_cnt=0.
REQ-019 In RISE or FALL, a game_over 0->1 edge -> OVER with over_cnt=0.
REQ-020 OVER: each tick increments over_cnt, saturating at OVER_HOLD; flap presses are ignored until over_cnt==OVER_HOLD, after which a press -> RISE.
REQ-021 From any state, a rst press -> RST with hold_cnt=0; RST holds 111 for exactly 2 ticks, then -> IDLE.
REQ-022 Same-cycle priority SHALL be rst press > game_over edge > flap press > tick expiry.
REQ-023 game_over SHALL be synchronised with 2 FFs before edge detection; a level already high when entering IDLE or OVER SHALL NOT count as an edge.
REQ-024 All counters SHALL be sized with $clog2 of their bound and SHALL never wrap past their terminal value.

Reset
REQ-025 On reset: state=IDLE, dir=000, tick=0, all counters 0, debounced levels 0, synchroniser and edge registers 0.
REQ-026 Reset mid-flap or mid-RST SHALL abandon the operation; no press event SHALL be generated for a button already held when reset deasserts.

Configuration
REQ-027 Macro FLAP_HOLD_EN: when defined, in RISE a still-high debounced flap level SHALL block the tick-expiry exit, so dir stays 010 while the button is held; when undefined, each flap lasts exactly FLAP_TICKS ticks regardless of the button.

Structure
REQ-028 Shared package flappy_pkg SHALL hold the dir codes (DIR_START, DIR_UP, DIR_DOWN, DIR_RESET) and the state enum, for reuse by the movement stage.
REQ-029 Sub-module btn_debounce (synchroniser, debouncer and rising-edge pulse) SHALL be instantiated twice, once per button.

Verification (DEB_CYCLES=4, TICK_DIV=10, FLAP_TICKS=3, OVER_HOLD=2)
REQ-030 Reset, btn_flap held high 8 cycles -> dir 000->010 about 7 cycles after press; 100 exactly 3 tick pulses later.
REQ-031 btn_flap toggling every 2 cycles for 40 cycles -> no press event, dir stays 000.
REQ-032 In FALL, game_over rises -> dir=000; a press before the 2nd tick is ignored; a press after it -> 010.
REQ-033 btn_rst press in the same cycle as a flap press in FALL -> dir=111 for 20 cycles (2 ticks), then 000.
REQ-034 FLAP_HOLD_EN defined, flap held 60 cycles -> dir stays 010 until the first tick after release; undefined -> 100 after 3 ticks while still held.
REQ-035 Reset asserted mid-RISE with btn_flap still high -> dir=000 and no RISE until release and re-press.
